// File: rtl/nrzi_pkg.sv
// Shared types and constants for the toggle-encoded frame receiver.
package nrzi_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } rx_state_t;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'h7E;
    localparam int         BYTE_W            = 8;

    // Byte counter width; a one-byte frame still needs a 1-bit counter.
    function automatic int byte_cnt_w(input int frame_bytes);
        return (frame_bytes <= 1) ? 1 : $clog2(frame_bytes);
    endfunction

endpackage

// File: rtl/nrzi_frame_rx_toggle_decoder.sv
// Inverse of the T-stage line encoder: a line change decodes as 1, a hold as 0.
module nrzi_toggle_decoder (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_en,
    input  logic line_in,
    output logic d,
    output logic d_valid
);

    logic line_q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q_reg <= 1'b0;
        end else if (bit_en) begin
            line_q_reg <= line_in;
        end
    end

    assign d       = line_in ^ line_q_reg;
    assign d_valid = bit_en;

endmodule

// File: rtl/nrzi_frame_rx.sv
// Toggle-decoded serial receiver: hunts for a sync byte, then deserializes a
// fixed-length frame into bytes presented on a valid/ready output register.
module nrzi_frame_rx
    import nrzi_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD   = SYNC_WORD_DEFAULT,
    parameter int         FRAME_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              line_in,
    input  logic              resync,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              in_sync,
    output logic              frame_end,
    output logic              overrun
);

    localparam int               CW        = byte_cnt_w(FRAME_BYTES);
    localparam logic [CW-1:0]    LAST_BYTE = CW'(FRAME_BYTES - 1);

    logic d;
    logic d_valid;

    nrzi_toggle_decoder u_decoder (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_en  (bit_en),
        .line_in (line_in),
        .d       (d),
        .d_valid (d_valid)
    );

    rx_state_t         state_reg;
    logic [BYTE_W-1:0] hunt_sr_reg;
    logic [BYTE_W-1:0] data_sr_reg;
    logic [2:0]        bit_cnt_reg;
    logic [CW-1:0]     byte_cnt_reg;

    logic [BYTE_W-1:0] hunt_sr_next;
    logic [BYTE_W-1:0] data_sr_next;
    logic              byte_done;
    logic              out_free;

    always_comb begin
        hunt_sr_next = {d, hunt_sr_reg[BYTE_W-1:1]};
        data_sr_next = {d, data_sr_reg[BYTE_W-1:1]};
        byte_done    = d_valid && (state_reg == PAYLOAD) && (bit_cnt_reg == 3'd7);
        // The output slot is free if empty or being drained on this same edge.
        out_free     = !out_valid || out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= HUNT;
            hunt_sr_reg  <= '0;
            data_sr_reg  <= '0;
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            in_sync      <= 1'b0;
            frame_end    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_end <= 1'b0;
            overrun   <= 1'b0;

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (resync) begin
                // Abort framing only; a byte already in the output stays deliverable.
                state_reg    <= HUNT;
                in_sync      <= 1'b0;
                hunt_sr_reg  <= '0;
                data_sr_reg  <= '0;
                bit_cnt_reg  <= '0;
                byte_cnt_reg <= '0;
            end else if (d_valid) begin
                case (state_reg)
                    HUNT: begin
                        if (hunt_sr_next == SYNC_WORD) begin
                            state_reg    <= PAYLOAD;
                            in_sync      <= 1'b1;
                            hunt_sr_reg  <= '0;
                            bit_cnt_reg  <= '0;
                            byte_cnt_reg <= '0;
                        end else begin
                            hunt_sr_reg <= hunt_sr_next;
                        end
                    end
                    PAYLOAD: begin
                        data_sr_reg <= data_sr_next;
                        if (byte_done) begin
                            bit_cnt_reg <= '0;
                            if (out_free) begin
                                out_data  <= data_sr_next;
                                out_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            if (byte_cnt_reg == LAST_BYTE) begin
                                frame_end    <= 1'b1;
                                state_reg    <= HUNT;
                                in_sync      <= 1'b0;
                                hunt_sr_reg  <= '0;
                                byte_cnt_reg <= '0;
                            end else begin
                                byte_cnt_reg <= byte_cnt_reg + CW'(1);
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        end
                    end
                    default: begin
                        state_reg <= HUNT;
                        in_sync   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nrzi_frame_rx.sv
// Directed bench: one-byte-frame and two-byte-frame receivers on shared stimulus.
module tb_nrzi_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_en = 1'b0;
    logic       line_in = 1'b0;
    logic       resync = 1'b0;
    logic       out_ready = 1'b0;
    logic       tb_line = 1'b0;

    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid, a_sync, b_sync, a_fend, b_fend, a_ovr, b_ovr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nrzi_frame_rx #(.SYNC_WORD(8'h7E), .FRAME_BYTES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .line_in(line_in), .resync(resync),
        .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready),
        .in_sync(a_sync), .frame_end(a_fend), .overrun(a_ovr)
    );

    nrzi_frame_rx #(.SYNC_WORD(8'h7E), .FRAME_BYTES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .line_in(line_in), .resync(resync),
        .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready),
        .in_sync(b_sync), .frame_end(b_fend), .overrun(b_ovr)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bit_en = 1'b0; resync = 1'b0; tb_line = 1'b0; line_in = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // T-stage encoder: a data 1 toggles the line, a 0 holds it.
    task automatic send_bit(input logic b);
        tb_line = tb_line ^ b;
        line_in = tb_line;
        bit_en  = 1'b1;
        @(posedge clk); #1;
        bit_en  = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[i]);
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        do_reset();
        rst_n = 1'b0; #1;
        chk("rst_valid", {7'd0, b_valid}, 8'd0);
        chk("rst_data", b_data, 8'h00);
        chk("rst_sync", {7'd0, b_sync}, 8'd0);
        chk("rst_fend", {7'd0, b_fend}, 8'd0);
        chk("rst_ovr", {7'd0, b_ovr}, 8'd0);

        // Sync + one byte, FRAME_BYTES=1
        do_reset();
        out_ready = 1'b1;
        send_bits(8'h7E, 7);
        chk("t1_sync_before", {7'd0, a_sync}, 8'd0);
        send_bit(1'b0);
        chk("t1_sync_after", {7'd0, a_sync}, 8'd1);
        send_bits(8'hA5, 8);
        chk("t1_data", a_data, 8'hA5);
        chk("t1_valid", {7'd0, a_valid}, 8'd1);
        chk("t1_fend", {7'd0, a_fend}, 8'd1);
        chk("t1_sync_drop", {7'd0, a_sync}, 8'd0);
        idle();
        chk("t1_valid_drop", {7'd0, a_valid}, 8'd0);
        chk("t1_fend_drop", {7'd0, a_fend}, 8'd0);

        // Backpressure / overrun, FRAME_BYTES=2
        do_reset();
        out_ready = 1'b0;
        send_bits(8'h7E, 8);
        send_bits(8'h11, 8);
        chk("t2_data1", b_data, 8'h11);
        chk("t2_valid1", {7'd0, b_valid}, 8'd1);
        send_bits(8'h22, 7);
        chk("t2_no_ovr_yet", {7'd0, b_ovr}, 8'd0);
        send_bit(1'b0);
        chk("t2_ovr", {7'd0, b_ovr}, 8'd1);
        chk("t2_fend", {7'd0, b_fend}, 8'd1);
        chk("t2_data_held", b_data, 8'h11);
        chk("t2_valid_held", {7'd0, b_valid}, 8'd1);
        idle();
        chk("t2_ovr_pulse", {7'd0, b_ovr}, 8'd0);
        chk("t2_sync_off", {7'd0, b_sync}, 8'd0);
        out_ready = 1'b1;
        idle();
        chk("t2_valid_done", {7'd0, b_valid}, 8'd0);
        out_ready = 1'b0;

        // Back-to-back accept
        do_reset();
        send_bits(8'h7E, 8);
        send_bits(8'h11, 8);
        send_bits(8'h22, 7);
        chk("t3_data_pre", b_data, 8'h11);
        out_ready = 1'b1;
        send_bit(1'b0);
        chk("t3_valid", {7'd0, b_valid}, 8'd1);
        chk("t3_data", b_data, 8'h22);
        chk("t3_ovr", {7'd0, b_ovr}, 8'd0);
        chk("t3_fend", {7'd0, b_fend}, 8'd1);
        idle();
        chk("t3_valid_drop", {7'd0, b_valid}, 8'd0);
        out_ready = 1'b0;

        // False sync in HUNT
        do_reset();
        send_bits(8'h7C, 8);
        chk("t4_no_sync_7c", {7'd0, b_sync}, 8'd0);
        send_bits(8'h7E, 7);
        chk("t4_no_sync_partial", {7'd0, b_sync}, 8'd0);
        send_bit(1'b0);
        chk("t4_sync", {7'd0, b_sync}, 8'd1);

        // resync mid-frame
        do_reset();
        out_ready = 1'b1;
        send_bits(8'h7E, 8);
        send_bits(8'h05, 3);
        chk("t5_sync_pre", {7'd0, b_sync}, 8'd1);
        resync = 1'b1;
        idle();
        resync = 1'b0;
        chk("t5_sync_off", {7'd0, b_sync}, 8'd0);
        chk("t5_no_valid", {7'd0, b_valid}, 8'd0);
        chk("t5_no_fend", {7'd0, b_fend}, 8'd0);
        send_bits(8'h7E, 8);
        chk("t5_resync", {7'd0, b_sync}, 8'd1);
        send_bits(8'h3C, 8);
        chk("t5_data", b_data, 8'h3C);
        chk("t5_valid", {7'd0, b_valid}, 8'd1);
        out_ready = 1'b0;

        // Async reset mid-byte with a pending output
        do_reset();
        send_bits(8'h7E, 8);
        send_bits(8'h5A, 8);
        send_bits(8'h03, 3);
        chk("t6_valid_pre", {7'd0, b_valid}, 8'd1);
        chk("t6_data_pre", b_data, 8'h5A);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_rst", {7'd0, b_valid}, 8'd0);
        chk("t6_sync_rst", {7'd0, b_sync}, 8'd0);
        chk("t6_data_rst", b_data, 8'h00);
        rst_n = 1'b1;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nrzi_frame_rx.md
Name: nrzi_frame_rx

Overview:
- Receive end of the team's toggle-encoded serial line. The transmit side is a T-type stage: a data '1' toggles the line and a data '0' holds it.
- This block recovers data bits by comparing each line sample with the previous one, hunts for an 8-bit sync word, then deserializes a fixed-length frame into bytes.
- Bytes are presented on a valid/ready output toward the consuming logic.

Parameters:
- SYNC_WORD, 8'h7E, decoded byte that marks frame start. Received LSB first.
- FRAME_BYTES, 4, payload bytes per frame. Legal range is 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- bit_en  in  1  line-sample strobe; one encoded bit per asserted cycle
- line_in  in  1  encoded serial line; sampled only when bit_en=1
- resync  in  1  synchronous abort; return to HUNT
- out_data  out  8  received payload byte
- out_valid  out  1  out_data is valid; held until accepted
- out_ready  in  1  consumer accepts when out_valid&out_ready
- in_sync  out  1  high while in PAYLOAD state
- frame_end  out  1  1-cycle pulse on the clock that completes the last byte of a frame
- overrun  out  1  1-cycle pulse when a completed byte is dropped

Behaviour:
- Reset (async, rst_n=0): line_q=0, state=HUNT, all shift registers and counters cleared, out_data=0, out_valid=0, in_sync=0, frame_end=0, overrun=0.
- Decode: on a bit_en cycle, d = line_in ^ line_q, then line_q <= line_in. With bit_en=0 nothing advances, including line_q.
- HUNT state:
  - On each bit_en, hunt_sr <= {d, hunt_sr[7:1]} (LSB first).
  - If the new value equals SYNC_WORD, go to PAYLOAD on that same edge, with bit_cnt=0, byte_cnt=0, hunt_sr=0.
- PAYLOAD state:
  - On each bit_en, data_sr <= {d, data_sr[7:1]} and bit_cnt increments.
  - When bit_cnt==7 on a bit_en cycle, the byte is complete (the new data_sr value) and bit_cnt wraps to 0.
- Byte completion vs. output register:
  - If out_valid==0, or out_valid&out_ready in the same cycle: out_data <= byte and out_valid <= 1. The byte is visible the cycle after its last bit's edge.
  - Otherwise: overrun=1 for one cycle, the byte is dropped, and out_data/out_valid are unchanged.
  - byte_cnt increments on every completed byte, whether dropped or not.
- Frame end: if the completed byte has byte_cnt==FRAME_BYTES-1, pulse frame_end, go to HUNT, and clear hunt_sr. Sync detection in the new HUNT starts from the next bit.
- Handshake: out_valid falls the cycle after out_valid&out_ready, unless a new byte loads on that same edge (back-to-back). out_ready while out_valid=0 has no effect.
- resync=1 (synchronous): state=HUNT and hunt_sr, data_sr, bit_cnt, byte_cnt are cleared. Priority is above bit processing in the same cycle.
  - line_q still updates if bit_en=1, so decode continuity is kept.
  - out_valid/out_data are untouched; a pending byte remains deliverable.
  - No frame_end pulse is generated.
- A sync pattern appearing inside the payload is treated as data and is not re-detected.
- Reset asserted mid-frame: immediate return to reset values, and any pending output byte is lost.
- in_sync is a registered state decode: 1 exactly while state==PAYLOAD.

Decomposition:
- Package nrzi_pkg holds:
  - the state enum {HUNT, PAYLOAD}
  - SYNC_WORD_DEFAULT = 8'h7E
  - BYTE_W = 8
  - the byte_cnt width function (clog2 of FRAME_BYTES, minimum 1)
- One sub-module, nrzi_toggle_decoder: line_q register plus XOR. It takes clk, rst_n, bit_en, line_in and outputs d and d_valid (= bit_en). It is the exact inverse of the team's T-stage encoder.
- The framing FSM, shifters and output register stay in nrzi_frame_rx.

Test Plan:
- Sync + one byte (FRAME_BYTES=1, out_ready=1, start line=0):
  - Stimulus: line 0,1,0,1,0,1,0,0 (decodes to 0x7E), then 1,1,0,0,0,1,1,0 (decodes to 0xA5).
  - Required: in_sync rises after the 8th bit; out_data=8'hA5 with out_valid for 1 cycle; frame_end pulses on the last bit's edge; in_sync returns to 0.
- Backpressure/overrun (FRAME_BYTES=2):
  - Stimulus: payload 0x11 then 0x22, with out_ready=0 throughout.
  - Required: out_data stays 0x11 with out_valid held; overrun pulses at the 2nd byte; after out_ready=1, one transfer of 0x11 and then out_valid=0.
- Back-to-back accept:
  - Stimulus: 2nd byte completes in the same cycle that 0x11 is accepted.
  - Required: out_valid stays 1, out_data becomes 0x22, no overrun.
- False sync in HUNT:
  - Stimulus: decoded stream 0x7C, then 0x7E.
  - Required: no in_sync after 0x7C; in_sync rises only at the bit completing 0x7E.
- resync mid-frame:
  - Stimulus: after 3 payload bits, resync=1 for 1 cycle.
  - Required: in_sync=0 next cycle, no out_valid, no frame_end; a following sync + payload 0x3C delivers 0x3C.
- Async reset mid-byte:
  - Stimulus: rst_n=0 between clock edges during PAYLOAD with out_valid=1.
  - Required: out_valid, in_sync and out_data all go to 0 immediately without waiting for clk.
